// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for serial_adder
//
// Signals:
//   start     request a new operation (master -> slave)
//   a, b      WIDTH-bit operands (master -> slave)
//   c_in      carry-in, ignored for subtraction (master -> slave)
//   sub       0 = a+b+c_in, 1 = a-b (master -> slave)
//   busy      operation in progress (slave -> master)
//   done      one-cycle pulse when results update (slave -> master)
//   sum       WIDTH-bit result, held between completions (slave -> master)
//   c_out     carry out of the MSB; for subtraction 1 = no borrow (slave -> master)
//   overflow  two's-complement overflow (slave -> master)
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one bit per clock, LSB first
//
// Parameters:
//   WIDTH  operand/result width, 2..32
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: start/a/b/c_in/sub in, busy/done/sum/c_out/overflow out
//
// An accepted start loads the operand shift registers (B inverted and carry
// forced to 1 for subtraction), then WIDTH RUN edges each resolve one result
// bit through a single carry flip-flop. Results are published only on the
// last RUN edge, so the outputs never show a partial sum.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only WIDTH-1 partial bits need storing: the final bit is merged
    // directly into sum on the completing edge.
    logic [WIDTH-2:0] ps_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] ps_next;

    assign bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign ps_next   = {bit_s, ps_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            ps_sr        <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sum      <= '0;
            bus.c_out    <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                // DONE accepts a start exactly like IDLE so operations can
                // run back-to-back at one result per WIDTH+1 cycles.
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr     <= bus.a;
                        b_sr     <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub ? 1'b1 : bus.c_in;
                        ps_sr    <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_nxt;
                    ps_sr <= ps_next[WIDTH-1:1];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        bus.sum      <= ps_next;
                        bus.c_out    <= carry_nxt;
                        // carry still holds the carry into the MSB here
                        bus.overflow <= carry ^ carry_nxt;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= DONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 8, 2 and 32
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(2))  bus2 ();
    serial_adder_if #(.WIDTH(32)) bus32 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_adder #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

    // Reference: plain wide arithmetic, result packed as {overflow, c_out, sum}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] mask, bb, full, low;
        logic        ci, cm, co;
        mask = (64'd1 << w) - 64'd1;
        bb   = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        ci   = sub ? 1'b1 : cin;
        full = ({32'd0, a} & mask) + bb + {63'd0, ci};
        low  = ({32'd0, a} & (mask >> 1)) + (bb & (mask >> 1)) + {63'd0, ci};
        cm   = low[w-1];
        co   = full[w];
        return {cm ^ co, co, full[31:0] & mask[31:0]};
    endfunction

    task automatic idle_inputs();
        bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.c_in = 0;  bus8.sub = 0;
        bus2.start = 0;  bus2.a = '0;  bus2.b = '0;  bus2.c_in = 0;  bus2.sub = 0;
        bus32.start = 0; bus32.a = '0; bus32.b = '0; bus32.c_in = 0; bus32.sub = 0;
    endtask

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.c_in = cin; bus8.sub = sub; bus8.start = 1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 0;
    endtask

    task automatic wait_done8(output int lat, output int busy_cnt, output bit ok);
        lat = 0; busy_cnt = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
            lat++;
            if (bus8.done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input logic [9:0] exp);
        int lat, bc;
        bit ok;
        start8(a, b, cin, sub);
        wait_done8(lat, bc, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s timeout got lat=%0d want done within 20", name, lat);
        end
        total++;
        if ({bus8.sum, bus8.c_out, bus8.overflow} !== exp) begin
            bad++;
            $display("FAIL %s result got %h want %h", name,
                     {bus8.sum, bus8.c_out, bus8.overflow}, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        total++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.overflow} !== 12'h000) begin
            bad++;
            $display("FAIL reset8 got %h want 000",
                     {bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.overflow});
        end
        total++;
        if ({bus32.busy, bus32.done, bus32.sum, bus32.c_out, bus32.overflow} !== 36'h0) begin
            bad++;
            $display("FAIL reset32 got %h want 0",
                     {bus32.busy, bus32.done, bus32.sum, bus32.c_out, bus32.overflow});
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_add_timing();
        int lat, bc;
        bit ok;
        start8(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done8(lat, bc, ok);
        total++;
        if (lat !== 8 || !ok) begin
            bad++;
            $display("FAIL add_latency got %0d want 8", lat);
        end
        total++;
        if (bc !== 8) begin
            bad++;
            $display("FAIL add_busy_cycles got %0d want 8", bc);
        end
        total++;
        if (bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL add_busy_in_done got %b want 0", bus8.busy);
        end
        total++;
        if ({bus8.sum, bus8.c_out, bus8.overflow} !== {8'h8D, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_5a_33 got %h want %h", {bus8.sum, bus8.c_out, bus8.overflow},
                     {8'h8D, 1'b0, 1'b1});
        end
        @(negedge clk);
        total++;
        if (bus8.done !== 1'b0 || bus8.sum !== 8'h8D) begin
            bad++;
            $display("FAIL add_done_pulse got done=%b sum=%h want done=0 sum=8d", bus8.done, bus8.sum);
        end
    endtask

    task automatic test_add_carry();
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
        run8("add_cin", 8'h00, 8'h00, 1'b1, 1'b0, {8'h01, 1'b0, 1'b0});
    endtask

    task automatic test_sub();
        // c_in=1 here must be ignored
        run8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, {8'hF0, 1'b0, 1'b0});
        run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        logic [9:0] res = '0;
        start8(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.sub = 1; bus8.start = 1;
        @(negedge clk);
        bus8.start = 0; bus8.a = 8'hAA; bus8.c_in = 1;
        for (int i = 0; i < 16; i++) begin
            if (bus8.done) begin
                n_done++;
                res = {bus8.sum, bus8.c_out, bus8.overflow};
            end
            @(negedge clk);
        end
        total++;
        if (n_done !== 1) begin
            bad++;
            $display("FAIL ignore_done_count got %0d want 1", n_done);
        end
        total++;
        if (res !== {8'h46, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ignore_result got %h want %h", res, {8'h46, 1'b0, 1'b0});
        end
        bus8.c_in = 0; bus8.sub = 0;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit ok;
        start8(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done8(lat, bc, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_first got done=%b want 1", bus8.done);
        end
        bus8.a = 8'h01; bus8.b = 8'h02; bus8.c_in = 0; bus8.sub = 0; bus8.start = 1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 0;
        total++;
        if ({bus8.busy, bus8.done, bus8.sum} !== {1'b1, 1'b0, 8'h8D}) begin
            bad++;
            $display("FAIL b2b_accept got %h want %h", {bus8.busy, bus8.done, bus8.sum},
                     {1'b1, 1'b0, 8'h8D});
        end
        repeat (7) @(negedge clk);
        total++;
        if ({bus8.done, bus8.sum} !== {1'b0, 8'h8D}) begin
            bad++;
            $display("FAIL b2b_hold got %h want %h", {bus8.done, bus8.sum}, {1'b0, 8'h8D});
        end
        @(negedge clk);
        total++;
        if ({bus8.done, bus8.sum, bus8.c_out, bus8.overflow} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_second got %h want %h", {bus8.done, bus8.sum, bus8.c_out, bus8.overflow},
                     {1'b1, 8'h03, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        start8(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.overflow} !== 12'h000) begin
            bad++;
            $display("FAIL midrun_reset got %h want 000",
                     {bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.overflow});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) n_done++;
        end
        total++;
        if (n_done !== 0) begin
            bad++;
            $display("FAIL midrun_no_done got %0d want 0", n_done);
        end
        run8("after_reset", 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
    endtask

    task automatic test_regress_w2();
        logic [31:0] a, b;
        logic        cin, sub;
        logic [33:0] exp;
        bit          ok;
        for (int n = 0; n < 500; n++) begin
            a = $urandom_range(0, 3); b = $urandom_range(0, 3);
            cin = 1'($urandom); sub = 1'($urandom);
            exp = model(2, a, b, cin, sub);
            @(negedge clk);
            bus2.a = a[1:0]; bus2.b = b[1:0]; bus2.c_in = cin; bus2.sub = sub; bus2.start = 1;
            @(posedge clk);
            @(negedge clk);
            bus2.start = 0;
            ok = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus2.done) begin
                    ok = 1;
                    break;
                end
            end
            total++;
            if (!ok || {bus2.overflow, bus2.c_out, bus2.sum} !== {exp[33:32], exp[1:0]}) begin
                bad++;
                $display("FAIL w2_op%0d a=%h b=%h cin=%b sub=%b got %h want %h done=%b", n, a[1:0], b[1:0],
                         cin, sub, {bus2.overflow, bus2.c_out, bus2.sum}, {exp[33:32], exp[1:0]}, ok);
            end
        end
    endtask

    task automatic test_regress_w32();
        logic [31:0] a, b;
        logic        cin, sub;
        logic [33:0] exp;
        bit          ok;
        for (int n = 0; n < 500; n++) begin
            a = $urandom; b = $urandom;
            cin = 1'($urandom); sub = 1'($urandom);
            exp = model(32, a, b, cin, sub);
            @(negedge clk);
            bus32.a = a; bus32.b = b; bus32.c_in = cin; bus32.sub = sub; bus32.start = 1;
            @(posedge clk);
            @(negedge clk);
            bus32.start = 0;
            ok = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus32.done) begin
                    ok = 1;
                    break;
                end
            end
            total++;
            if (!ok || {bus32.overflow, bus32.c_out, bus32.sum} !== exp) begin
                bad++;
                $display("FAIL w32_op%0d a=%h b=%h cin=%b sub=%b got %h want %h done=%b", n, a, b,
                         cin, sub, {bus32.overflow, bus32.c_out, bus32.sum}, exp, ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_add_carry();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_regress_w2();
        test_regress_w32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that applies the one-bit full-adder relation over a WIDTH-bit operand pair, one bit per clock, LSB first, using a single carry flip-flop. It gives the datapath a small-area multi-cycle arithmetic unit with a start/busy/done handshake. Results are held stable until the next operation completes.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- c_in  input  1  carry-in; captured on the accepting edge; ignored when sub=1.
- sub  input  1  0 = A+B+c_in, 1 = A-B; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results update.
- sum  output  WIDTH  result; held between completions.
- c_out  output  1  carry out of the MSB. For subtraction, 1 means no borrow (A>=B unsigned).
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures a into the A shift register.
  - Captures b into the B shift register, inverted when sub=1.
  - Sets carry = sub ? 1 : c_in.
  - Clears the bit counter and the partial-sum shift register.
  - Goes to RUN.
- RUN, each edge:
  - Bit s = A[0] ^ B[0] ^ carry.
  - carry <= majority(A[0], B[0], carry).
  - A and B shift right.
  - s shifts into the partial-sum MSB.
  - Counter increments.
- Last RUN edge (counter = WIDTH-1):
  - sum <= final partial sum.
  - c_out <= new carry.
  - overflow <= old carry (the carry into the MSB) XOR new carry.
  - done <= 1; goes to DONE.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - start=1 is accepted exactly as in IDLE (back-to-back), going to RUN.
  - Otherwise goes to IDLE.
- start is ignored while busy=1. Input changes during RUN have no effect.
- sum, c_out and overflow change only on the completing edge. They never expose partial results.
- Counter width is clog2(WIDTH). There is no wrap beyond WIDTH-1 because the state leaves RUN.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - State = IDLE.
  - busy=0, done=0, sum=0, c_out=0, overflow=0.
  - Internal shift registers, carry and counter = 0.
  - The in-progress operation is discarded; no done pulse is produced.
- Let E0 be the accepting edge.
- busy=1 after E0 through the edge E_WIDTH. There are exactly WIDTH RUN edges, E1..E_WIDTH.
- sum, c_out, overflow and done=1 are all registered on E_WIDTH.
- busy=0 after E_WIDTH. Latency from accepting edge to result is WIDTH cycles.
- done falls after E_WIDTH+1 unless a new start is accepted on that edge. Even then, done falls after that edge.
- Maximum throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Deassertion of rst_n is treated as synchronous to clk by the system.

## Test plan
- WIDTH=8, add 0x5A+0x33, c_in=0 -> sum=0x8D, c_out=0, overflow=1. done pulses exactly 8 cycles after the start edge, and busy is high for exactly 8 cycles.
- WIDTH=8, add 0xFF+0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0. Then 0x00+0x00 with c_in=1 -> sum=0x01, c_out=0, overflow=0.
- WIDTH=8, sub 0x10-0x20 -> sum=0xF0, c_out=0, overflow=0. Sub 0x80-0x01 -> sum=0x7F, c_out=1, overflow=1.
- Pulse start with new operands during busy, then change a/b mid-RUN -> the result matches the originally captured operands. Exactly one done pulse occurs.
- Assert start in the DONE cycle with 0x01+0x02 -> the second op is accepted, and sum=0x03 appears 8 cycles later. The first result stays visible until then.
- Pulse rst_n low at RUN cycle 4 -> all outputs are immediately 0, no done pulse, and the state is IDLE. A subsequent 0x7F+0x01 gives sum=0x80, overflow=1.
- WIDTH=2 and WIDTH=32 regressions -> 500 random add/sub ops each match a reference model.
